// File: rtl/store_result_checker.sv
// Self-check monitor for the core's data-memory write port: classifies every store and
// latches a PASS/FAIL/TIMEOUT verdict plus the first offending store.
module store_result_checker #(
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned PASS_ADDR = 100,
  parameter int unsigned PASS_DATA = 25,
  parameter int unsigned SCR_LO    = 96,
  parameter int unsigned SCR_HI    = 96,
  parameter int unsigned TIMEOUT   = 1000,
  parameter int unsigned CW        = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          MemWrite,
  input  logic [AW-1:0] DataAdr,
  input  logic [DW-1:0] WriteData,
  output logic          done,
  output logic          pass,
  output logic          fail,
  output logic          timeout,
  output logic [CW-1:0] write_count,
  output logic [CW-1:0] cycle_count,
  output logic [AW-1:0] fail_addr,
  output logic [DW-1:0] fail_data
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_PASS,
    ST_FAIL,
    ST_TMO
  } state_e;

  localparam logic [AW-1:0] PASS_A   = AW'(PASS_ADDR);
  localparam logic [DW-1:0] PASS_D   = DW'(PASS_DATA);
  localparam logic [AW-1:0] SCR_L    = AW'(SCR_LO);
  localparam logic [AW-1:0] SCR_H    = AW'(SCR_HI);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [AW-1:0] faddr_q, faddr_d;
  logic [DW-1:0] fdata_q, fdata_d;

  logic isPassAdr;
  logic inScratch;

  assign isPassAdr = (DataAdr == PASS_A);
  assign inScratch = (DataAdr >= SCR_L) && (DataAdr <= SCR_H);

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    cyc_d   = cyc_q;
    faddr_d = faddr_q;
    fdata_d = fdata_q;
    if (clear) begin
      state_d = ST_RUN;
      wcnt_d  = '0;
      cyc_d   = '0;
      faddr_d = '0;
      fdata_d = '0;
    end else if (state_q == ST_RUN) begin
      if (cyc_q != CNT_MAX) cyc_d = cyc_q + CW'(1);
      // The pass address is checked first so it wins even inside the scratch window.
      if (MemWrite && isPassAdr) begin
        if (WriteData == PASS_D) begin
          state_d = ST_PASS;
        end else begin
          state_d = ST_FAIL;
          faddr_d = DataAdr;
          fdata_d = WriteData;
        end
      end else if (MemWrite && inScratch) begin
        if (wcnt_q != CNT_MAX) wcnt_d = wcnt_q + CW'(1);
      end else if (MemWrite) begin
        state_d = ST_FAIL;
        faddr_d = DataAdr;
        fdata_d = WriteData;
      end
      if ((state_d == ST_RUN) && (cyc_q == TMO_LAST)) state_d = ST_TMO;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      wcnt_q  <= '0;
      cyc_q   <= '0;
      faddr_q <= '0;
      fdata_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      cyc_q   <= cyc_d;
      faddr_q <= faddr_d;
      fdata_q <= fdata_d;
    end
  end

  assign done        = (state_q != ST_RUN);
  assign pass        = (state_q == ST_PASS);
  assign fail        = (state_q == ST_FAIL);
  assign timeout     = (state_q == ST_TMO);
  assign write_count = wcnt_q;
  assign cycle_count = cyc_q;
  assign fail_addr   = faddr_q;
  assign fail_data   = fdata_q;

endmodule

// File: tb/tb_store_result_checker.sv
// Scoreboard bench for store_result_checker: a verdict-level model predicts the outputs after
// each clock edge, and a negedge monitor compares them against the DUT.
module tb_store_result_checker;

  localparam int TMO = 20;

  localparam int V_RUN  = 0;
  localparam int V_PASS = 1;
  localparam int V_FAIL = 2;
  localparam int V_TMO  = 3;

  logic        clk;
  logic        reset;
  logic        clear;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic        done, pass, fail, timeout;
  logic [15:0] write_count, cycle_count;
  logic [31:0] fail_addr, fail_data;

  store_result_checker #(
    .AW(32), .DW(32), .PASS_ADDR(100), .PASS_DATA(25),
    .SCR_LO(96), .SCR_HI(96), .TIMEOUT(TMO), .CW(16)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear), .MemWrite(MemWrite),
    .DataAdr(DataAdr), .WriteData(WriteData),
    .done(done), .pass(pass), .fail(fail), .timeout(timeout),
    .write_count(write_count), .cycle_count(cycle_count),
    .fail_addr(fail_addr), .fail_data(fail_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        done, pass, fail, tmo;
    logic [15:0] wc, cc;
    logic [31:0] fa, fd;
  } exp_t;

  exp_t expQ[$];
  int   compared   = 0;
  int   mismatched = 0;

  // Reference model: what the test has seen so far, in verdict terms.
  int          mVerdict;
  int          mWrites;
  int          mCycles;
  logic [31:0] mFailAddr;
  logic [31:0] mFailData;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void modelReset();
    mVerdict  = V_RUN;
    mWrites   = 0;
    mCycles   = 0;
    mFailAddr = '0;
    mFailData = '0;
  endfunction

  function automatic void modelStep(input logic clr, input logic mw, input logic [31:0] adr,
                                    input logic [31:0] dat);
    exp_t e;
    if (clr) begin
      modelReset();
    end else if (mVerdict == V_RUN) begin
      if (mw && adr == 32'd100) begin
        if (dat == 32'd25) mVerdict = V_PASS;
        else begin
          mVerdict  = V_FAIL;
          mFailAddr = adr;
          mFailData = dat;
        end
      end else if (mw && adr == 32'd96) begin
        if (mWrites < 65535) mWrites++;
      end else if (mw) begin
        mVerdict  = V_FAIL;
        mFailAddr = adr;
        mFailData = dat;
      end
      if (mVerdict == V_RUN && mCycles + 1 == TMO) mVerdict = V_TMO;
      if (mCycles < 65535) mCycles++;
    end
    e.done = (mVerdict != V_RUN);
    e.pass = (mVerdict == V_PASS);
    e.fail = (mVerdict == V_FAIL);
    e.tmo  = (mVerdict == V_TMO);
    e.wc   = 16'(mWrites);
    e.cc   = 16'(mCycles);
    e.fa   = mFailAddr;
    e.fd   = mFailData;
    expQ.push_back(e);
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("done", done, e.done);
      checkOutput("pass", pass, e.pass);
      checkOutput("fail", fail, e.fail);
      checkOutput("timeout", timeout, e.tmo);
      checkOutput("write_count", write_count, e.wc);
      checkOutput("cycle_count", cycle_count, e.cc);
      checkOutput("fail_addr", fail_addr, e.fa);
      checkOutput("fail_data", fail_data, e.fd);
    end
  end

  task automatic applyStimulus(input logic clr, input logic mw, input logic [31:0] adr,
                               input logic [31:0] dat);
    clear     = clr;
    MemWrite  = mw;
    DataAdr   = adr;
    WriteData = dat;
    @(posedge clk);
    modelStep(clr, mw, adr, dat);
    #1;
    clear     = 1'b0;
    MemWrite  = 1'b0;
    DataAdr   = $urandom;
    WriteData = $urandom;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_pass"}, pass, 0);
    checkOutput({tag, "_fail"}, fail, 0);
    checkOutput({tag, "_timeout"}, timeout, 0);
    checkOutput({tag, "_wc"}, write_count, 0);
    checkOutput({tag, "_cc"}, cycle_count, 0);
    checkOutput({tag, "_faddr"}, fail_addr, 0);
    checkOutput({tag, "_fdata"}, fail_data, 0);
  endtask

  task automatic asyncReset(input string tag);
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    checkAllZero(tag);
    modelReset();
    @(negedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin : stimulus
    int storeProb;
    int r;
    int a;
    logic [31:0] adr;
    logic [31:0] dat;
    reset     = 1'b0;
    clear     = 1'b0;
    MemWrite  = 1'b0;
    DataAdr   = '0;
    WriteData = '0;
    modelReset();
    #3;
    checkAllZero("reset");
    @(negedge clk);
    reset = 1'b1;

    applyStimulus(0, 1, 96, 7);
    applyStimulus(0, 1, 96, 9);
    applyStimulus(0, 1, 100, 25);
    checkOutput("t1_pass", pass, 1);
    checkOutput("t1_done", done, 1);
    checkOutput("t1_fail", fail, 0);
    checkOutput("t1_wc", write_count, 2);

    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 100, 24);
    checkOutput("t2_fail", fail, 1);
    checkOutput("t2_faddr", fail_addr, 100);
    checkOutput("t2_fdata", fail_data, 24);
    applyStimulus(0, 1, 100, 25);
    checkOutput("t2_pass_stays0", pass, 0);

    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 96, 3);
    applyStimulus(0, 1, 104, 25);
    checkOutput("t3_fail", fail, 1);
    checkOutput("t3_faddr", fail_addr, 104);
    checkOutput("t3_wc", write_count, 1);

    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < TMO - 1; i++) applyStimulus(0, 0, 0, 0);
    checkOutput("t4_no_tmo_yet", timeout, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("t4_timeout", timeout, 1);
    checkOutput("t4_cc", cycle_count, TMO);
    applyStimulus(0, 0, 0, 0);
    checkOutput("t4_cc_frozen", cycle_count, TMO);

    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < TMO - 1; i++) applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 1, 100, 25);
    checkOutput("t5_pass", pass, 1);
    checkOutput("t5_timeout", timeout, 0);

    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 96, 1);
    applyStimulus(0, 1, 104, 0);
    checkOutput("t6_in_fail", fail, 1);
    applyStimulus(1, 1, 96, 1);
    checkOutput("t6_done", done, 0);
    checkOutput("t6_wc", write_count, 0);
    checkOutput("t6_faddr", fail_addr, 0);
    applyStimulus(0, 1, 96, 1);
    applyStimulus(0, 0, 0, 0);
    asyncReset("t6_async");

    storeProb = 20;
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 2 || (mVerdict != V_RUN && $urandom_range(0, 3) == 0)) begin
        storeProb = $urandom_range(2, 50);
        applyStimulus(1, $urandom_range(0, 1), 96, $urandom);
      end else if (r < storeProb + 2) begin
        a   = $urandom_range(0, 9);
        dat = $urandom;
        case (a)
          0, 1, 2, 3, 4: adr = 32'd96;
          5: begin
            adr = 32'd100;
            if ($urandom_range(0, 1) == 1) dat = 32'd25;
          end
          6: adr = 32'd95;
          7: adr = 32'd97;
          8: adr = 32'd104;
          default: adr = $urandom;
        endcase
        applyStimulus(0, 1, adr, dat);
      end else begin
        applyStimulus(0, 0, $urandom, $urandom);
      end
      if (n == 1500) asyncReset("rand_async");
    end

    @(negedge clk);
    #1;
    checkOutput("queue_drained", expQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
